// File: rtl/gnr_ctrl_pkg.sv
// Shared types and default sizing for the gene-regulatory-network attractor controller.
// The state vector typedef matches the default node count.
package gnr_ctrl_pkg;

    localparam int DEF_N_NODES   = 8;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_MAX_STEPS = 1024;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_STEP  = 3'd2,
        S_CMP   = 3'd3,
        S_PSTEP = 3'd4,
        S_PCMP  = 3'd5,
        S_FIN   = 3'd6
    } gnr_state_t;

    typedef logic [DEF_N_NODES-1:0] gnr_vec_t;

endpackage

// File: rtl/gnr_attractor_ctrl.sv
// Floyd tortoise/hare attractor search controller for a bank of GRN nodes.
// Define GNR_ATTR_PERIOD_EN to include the period-measurement phase (PSTEP/PCMP).
module gnr_attractor_ctrl
    import gnr_ctrl_pkg::*;
#(
    parameter int N_NODES   = DEF_N_NODES,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int MAX_STEPS = DEF_MAX_STEPS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] init_vec,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [CNT_W-1:0]   meet_steps,
    output logic [CNT_W-1:0]   period,
    output logic [N_NODES-1:0] attractor,
    output logic [2:0]         state_dbg
);

    // start is a level request: it is taken only in IDLE and ignored while busy;
    // done is a single-cycle pulse, results stay valid until the next accepted start.

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_STEPS);

    gnr_state_t         state, state_next;
    logic [CNT_W-1:0]   pulse_cnt;
    logic [N_NODES-1:0] init_q;
    logic [N_NODES-1:0] attr_q;
    logic [CNT_W-1:0]   meet_q;
    logic               timeout_q;
    logic               vec_eq;
    logic               meet_hit;

    assign vec_eq   = (s0_vec == s1_vec);
    // After an odd pulse count both walkers have taken one step and trivially agree.
    assign meet_hit = ~pulse_cnt[0] & vec_eq;

`ifdef GNR_ATTR_PERIOD_EN
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] period_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_LOAD;
            S_LOAD:  state_next = S_STEP;
            S_STEP:  state_next = S_CMP;
            S_CMP: begin
                if (meet_hit) begin
`ifdef GNR_ATTR_PERIOD_EN
                    state_next = S_PSTEP;
`else
                    state_next = S_FIN;
`endif
                end else if (pulse_cnt == MAX_C) begin
                    state_next = S_FIN;
                end else begin
                    state_next = S_STEP;
                end
            end
`ifdef GNR_ATTR_PERIOD_EN
            S_PSTEP: state_next = S_PCMP;
            S_PCMP: begin
                if (vec_eq || per_cnt == MAX_C) state_next = S_FIN;
                else                            state_next = S_PSTEP;
            end
`endif
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        reset_nos = (state == S_LOAD);
        start_s0  = (state == S_STEP);
        start_s1  = (state == S_STEP) || (state == S_PSTEP);
        busy      = (state != S_IDLE) && (state != S_FIN);
        done      = (state == S_FIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_cnt <= '0;
            init_q    <= '0;
            attr_q    <= '0;
            meet_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pulse_cnt <= '0;
                        init_q    <= init_vec;
                        attr_q    <= '0;
                        meet_q    <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                S_STEP: begin
                    if (pulse_cnt != MAX_C) pulse_cnt <= pulse_cnt + CNT_W'(1);
                end
                S_CMP: begin
                    if (meet_hit) begin
                        meet_q <= pulse_cnt;
                        attr_q <= s0_vec;
                    end else if (pulse_cnt == MAX_C) begin
                        timeout_q <= 1'b1;
                    end
                end
`ifdef GNR_ATTR_PERIOD_EN
                S_PCMP: begin
                    if (!vec_eq && per_cnt == MAX_C) timeout_q <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef GNR_ATTR_PERIOD_EN
    // Hare walks alone from the meet point until it returns to the frozen tortoise.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt  <= '0;
            period_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        per_cnt  <= '0;
                        period_q <= '0;
                    end
                end
                S_CMP: begin
                    if (meet_hit) per_cnt <= '0;
                end
                S_PSTEP: begin
                    if (per_cnt != MAX_C) per_cnt <= per_cnt + CNT_W'(1);
                end
                S_PCMP: begin
                    if (vec_eq) period_q <= per_cnt;
                end
                default: ;
            endcase
        end
    end
    assign period = period_q;
`else
    assign period = '0;
`endif

    assign init_state = init_q;
    assign attractor  = attr_q;
    assign meet_steps = meet_q;
    assign timeout    = timeout_q;
    assign state_dbg  = state;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Directed bench for gnr_attractor_ctrl with a behavioural node bank (N_NODES=4, MAX_STEPS=8).
// Expectations follow whether GNR_ATTR_PERIOD_EN is defined for the build.
module tb_gnr_attractor_ctrl;
    import gnr_ctrl_pkg::*;

    localparam int NN = 4;
    localparam int CW = 16;
    localparam int MS = 8;
`ifdef GNR_ATTR_PERIOD_EN
    localparam int P_EN = 1;
`else
    localparam int P_EN = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [NN-1:0] init_vec = '0;
    logic [NN-1:0] s0_vec, s1_vec;
    logic          reset_nos, start_s0, start_s1, busy, done, timeout;
    logic [NN-1:0] init_state, attractor;
    logic [CW-1:0] meet_steps, period;
    logic [2:0]    state_dbg;

    int checks = 0;
    int failures = 0;
    int mode = 0;
    int done_cnt = 0, rnos_cnt = 0, s1_cnt = 0;
    logic pass_q;

    always #5 clk = ~clk;

    gnr_attractor_ctrl #(.N_NODES(NN), .CNT_W(CW), .MAX_STEPS(MS)) dut (
        .clk(clk), .rst(rst), .start(start), .init_vec(init_vec),
        .s0_vec(s0_vec), .s1_vec(s1_vec), .reset_nos(reset_nos),
        .init_state(init_state), .start_s0(start_s0), .start_s1(start_s1),
        .busy(busy), .done(done), .timeout(timeout), .meet_steps(meet_steps),
        .period(period), .attractor(attractor), .state_dbg(state_dbg)
    );

    // Node bank model: 0 identity, 1 cycle 1->2->3->1, 2 increment mod 16.
    function automatic logic [NN-1:0] f_next(input logic [NN-1:0] x);
        logic [NN-1:0] r;
        r = x;
        if (mode == 2) r = x + 4'd1;
        else if (mode == 1) begin
            case (x)
                4'd1: r = 4'd2;
                4'd2: r = 4'd3;
                4'd3: r = 4'd1;
                default: r = x;
            endcase
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset_nos) begin
            s0_vec <= init_state;
            s1_vec <= init_state;
            pass_q <= 1'b0;
        end else begin
            if (start_s1) s1_vec <= f_next(s1_vec);
            if (start_s0) begin
                pass_q <= ~pass_q;
                if (!pass_q) s0_vec <= f_next(s0_vec);
            end
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (reset_nos) rnos_cnt++;
        if (start_s1) s1_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raises start at a falling edge and counts falling edges until done is seen.
    task automatic do_search(input logic [NN-1:0] iv, input bit hold, output int n, output bit ok);
        @(negedge clk);
        init_vec = iv;
        start = 1'b1;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1 && !hold) start = 1'b0;
            if (n == 1) check("load_timeout_cleared", {31'd0, timeout}, 32'd0);
            if (done) ok = 1'b1;
        end
        start = 1'b0;
        check("done_within_budget", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        int n;
        bit ok;
        int d0, r0, p0;

        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ctrl", {29'd0, reset_nos, start_s0, start_s1}, 32'd0);
        check("rst_results", {meet_steps, period}, 32'd0);
        check("rst_vecs", {24'd0, init_state, attractor}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Fixed point f(x)=x from 0x5
        mode = 0;
        d0 = done_cnt;
        do_search(4'h5, 1'b0, n, ok);
        check("fp_latency", n, 32'(6 + 2 * P_EN));
        check("fp_meet", meet_steps, 32'd2);
        check("fp_period", period, 32'(P_EN));
        check("fp_attr", attractor, 32'h5);
        check("fp_timeout", timeout, 32'd0);
        check("fp_init_state", init_state, 32'h5);
        check("fp_busy_at_done", busy, 32'd0);
        @(negedge clk);
        check("fp_done_one_cycle", done, 32'd0);
        check("fp_done_count", done_cnt - d0, 32'd1);

        // Three-cycle attractor from 1
        mode = 1;
        do_search(4'h1, 1'b0, n, ok);
        check("c3_latency", n, 32'(14 + 6 * P_EN));
        check("c3_meet", meet_steps, 32'd6);
        check("c3_period", period, 32'(3 * P_EN));
        check("c3_attr", attractor, 32'h1);
        repeat (5) @(negedge clk);
        check("c3_meet_held", meet_steps, 32'd6);
        check("c3_attr_held", attractor, 32'h1);

        // Timeout: increment never meets within MAX_STEPS pulses
        mode = 2;
        p0 = s1_cnt;
        do_search(4'h0, 1'b0, n, ok);
        check("to_latency", n, 32'd18);
        check("to_timeout", timeout, 32'd1);
        check("to_meet", meet_steps, 32'd0);
        check("to_period", period, 32'd0);
        check("to_s1_pulses", s1_cnt - p0, 32'd8);
        repeat (4) @(negedge clk);
        check("to_timeout_held", timeout, 32'd1);

        // start held high for the whole search
        mode = 1;
        d0 = done_cnt;
        r0 = rnos_cnt;
        do_search(4'h1, 1'b1, n, ok);
        check("hold_latency", n, 32'(14 + 6 * P_EN));
        check("hold_meet", meet_steps, 32'd6);
        repeat (4) @(negedge clk);
        check("hold_busy_after", busy, 32'd0);
        check("hold_done_count", done_cnt - d0, 32'd1);
        check("hold_reset_nos_count", rnos_cnt - r0, 32'd1);

        // rst mid-search, then a fresh search
        mode = 1;
        d0 = done_cnt;
        @(negedge clk);
        init_vec = 4'h1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
`ifdef GNR_ATTR_PERIOD_EN
        while (state_dbg != S_PSTEP && n < 100) begin
`else
        while (state_dbg != S_STEP && n < 100) begin
`endif
            @(negedge clk);
            n++;
        end
        check("mid_reach_state", {31'd0, n < 100}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_state_idle", state_dbg, 32'(S_IDLE));
        check("mid_ctrl_low", {reset_nos, start_s0, start_s1, busy, done}, 32'd0);
        check("mid_results_zero", {meet_steps, period}, 32'd0);
        check("mid_vecs_zero", {timeout, init_state, attractor}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_no_done", done_cnt - d0, 32'd0);
        do_search(4'h2, 1'b0, n, ok);
        check("fresh_latency", n, 32'(14 + 6 * P_EN));
        check("fresh_meet", meet_steps, 32'd6);
        check("fresh_period", period, 32'(3 * P_EN));
        check("fresh_attr", attractor, 32'h2);
        check("fresh_timeout", timeout, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
